inverse_revaluate: RTL and testbench
====================================

# inverse_revaluate

Sequential inverse of the revaluate (chi) step of the matrix encoder: recovers the pre-revaluate state from a revaluated `NUM_CELLS`-bit state. It processes one 5-cell row group per cycle, so the decoder path can undo the encoder's revaluate stage. It sits in the decoder pipeline between the preceding inverse stage and the state register, and uses the same `ISA.v` geometry and the same cell addressing as the encoder.

## Interface

- `NUM_ROW` (`ISA.v`), 5: cells per row group; index `i`.
- `NUM_COLUMN` (`ISA.v`), 5: index `j`.
- `NUM_PAGE` (`ISA.v`), 64: index `k`.
- `NUM_CELLS` (`ISA.v`), 1600: state width; cell address = `k*25 + j*5 + i`.
- `clk` in 1: single clock; everything on rising edge.
- `rst` in 1: synchronous, active-high reset.
- `start` in 1: request; sampled only in IDLE.
- `data_in` in `NUM_CELLS`: revaluated state; captured on the accepted `start`.
- `busy` out 1: high from the cycle after acceptance until `done`.
- `done` out 1: one-cycle pulse when `data_out` is complete.
- `data_out` out `NUM_CELLS`: recovered state; held until the next accepted `start` or `rst`.

## Operation

- Forward chi on a 5-bit group `a` (bit `i` = cell `i`): `chi(a)[i] = a[i] ^ (~a[(i+1)%5] & a[(i+2)%5])`.
  - chi is a bijection on 5 bits.
  - `inv(r)` is the unique `x` with `chi(x) = r`. It is implemented as a 32-entry constant table or equivalent logic.
- Group index `g = k*5 + j`, 9-bit, range 0..319.
  - The group occupies cells `5g .. 5g+4`.
  - Cell `i` of the group is address `5g + i`.
- FSM states:
  - IDLE: `start` moves to RUN, loads `data_in` into an internal 1600-bit capture register, and sets `g = 0`.
  - RUN: each cycle writes `data_out[5g+4:5g] <= inv(cap[5g+4:5g])`.
    - When `g == 319`: go to DONE and set `g` to 0.
    - Otherwise: `g <= g + 1`.
  - DONE: asserts `done` for exactly one cycle, then returns to IDLE.
- `start` in RUN or DONE is ignored. `data_in` is don't-care after capture.
- `data_out` bits not yet written in a run keep their previous value. Only `done` qualifies the result.
- Reset values: state IDLE, `g = 0`, `busy = 0`, `done = 0`, `data_out = 0`, capture register 0.
- `rst` mid-run has priority over everything:
  - next cycle is IDLE with all reset values;
  - no `done` is produced;
  - `start` in the same cycle as `rst` is dropped.

## Timing

- Cycle 0: `start = 1` in IDLE, accepted.
- Cycles 1..320: RUN, `busy = 1`. Group `g` is written at the end of cycle `g + 1`.
- Cycle 321: DONE, `done = 1`, `busy = 0`, `data_out` final.
- Cycle 322: IDLE. The earliest next acceptance is cycle 322.
- Latency is `start` to `done` = 321 cycles.
- Counter wrap: after group 319 the counter returns to 0. The last group occupies cells 1595..1599 (`k = 63`, `j = 4`).

## Configuration

- `INV_REVALUATE_DUAL_EN` defined:
  - two groups per RUN cycle (`g` and `g + 1`); `g` steps by 2 (0, 2, …, 318);
  - RUN lasts 160 cycles; `done` at cycle 161; latency 161.
  - Two `inv` instances are used.
- Not defined:
  - one group per cycle as specified above; latency 321.
- Port list and reset behaviour are identical in both builds.

## Test plan

- Reset, then `start` with `data_in = 0` → `done` only at cycle 321 (161 in the dual build), `data_out = 0`, and `busy` high for exactly 320 (160) cycles.
- `data_in` all ones → `data_out` all ones, because `chi(11111) = 11111`.
- `data_in` with only cells 0 and 3 set (group 0 = `0x09`) → `data_out` has only cell 0 set, because `inv(0x09) = 0x01`.
- Group 319 = `0x09` (cells 1595 and 1598 set), all else 0 → only cell 1595 set. This checks the wrap and last-group addressing.
- 100 random 1600-bit states `s`; feed `data_in = chi(s)` applied per group → `data_out == s` each time.
- Assert `rst` at cycle 100 of a run → `busy`, `done` and `data_out` are 0 next cycle and no `done` follows. A `start` asserted at cycle 50 of a fresh run is ignored, and `done` still arrives at cycle 321.

Source files
------------

// File: rtl/inverse_revaluate_if.sv
// Handshake and data bundle for the inverse revaluate stage.
// The master side drives start and data_in; the slave side returns busy, done and data_out.
interface inverse_revaluate_if #(
  parameter int NUM_CELLS = 1600
);
  logic                 start;
  logic [NUM_CELLS-1:0] data_in;
  logic                 busy;
  logic                 done;
  logic [NUM_CELLS-1:0] data_out;

  modport master (output start, data_in, input busy, done, data_out);
  modport slave  (input start, data_in, output busy, done, data_out);
endinterface

// File: rtl/inverse_revaluate.sv
// Sequential inverse of the chi (revaluate) step, one 5-cell row group per RUN cycle.
// Define INV_REVALUATE_DUAL_EN to process two groups per RUN cycle (half the latency).
//
// state  | meaning
// IDLE   | waiting for start; data_out holds the last result
// RUN    | inverting group g (and g+1 in the dual build) from the capture register
// DONE   | one-cycle done pulse, data_out complete
module inverse_revaluate (
  input  logic                 clk,
  input  logic                 rst,
  inverse_revaluate_if.slave   bus
);
  localparam int NUM_ROW    = 5;
  localparam int NUM_COLUMN = 5;
  localparam int NUM_PAGE   = 64;
  localparam int NUM_CELLS  = NUM_ROW * NUM_COLUMN * NUM_PAGE;
  localparam int NUM_GROUPS = NUM_COLUMN * NUM_PAGE;

`ifdef INV_REVALUATE_DUAL_EN
  localparam logic [8:0] G_STEP = 9'd2;
`else
  localparam logic [8:0] G_STEP = 9'd1;
`endif
  localparam logic [8:0] G_LAST = 9'(NUM_GROUPS) - G_STEP;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  function automatic logic [4:0] chi5(input logic [4:0] a);
    logic [4:0] r;
    for (int i = 0; i < 5; i++)
      r[i] = a[i] ^ (~a[(i + 1) % 5] & a[(i + 2) % 5]);
    return r;
  endfunction

  // chi is a bijection, so exactly one of the 32 candidates matches
  function automatic logic [4:0] inv5(input logic [4:0] r);
    logic [4:0] x;
    x = '0;
    for (int c = 0; c < 32; c++)
      if (chi5(5'(c)) == r) x = 5'(c);
    return x;
  endfunction

  logic [1:0]           state_q, state_d;
  logic [8:0]           g_q, g_d;
  logic [NUM_CELLS-1:0] cap_q, cap_d;
  logic [NUM_CELLS-1:0] out_q, out_d;
  logic [10:0]          base;

  assign base = 11'(g_q) * 11'(NUM_ROW);

  always_comb begin
    state_d = state_q;
    g_d     = g_q;
    cap_d   = cap_q;
    out_d   = out_q;
    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          state_d = S_RUN;
          cap_d   = bus.data_in;
          g_d     = '0;
        end
      end
      S_RUN: begin
        out_d[base +: 5] = inv5(cap_q[base +: 5]);
`ifdef INV_REVALUATE_DUAL_EN
        out_d[base + 11'd5 +: 5] = inv5(cap_q[base + 11'd5 +: 5]);
`endif
        if (g_q == G_LAST) begin
          state_d = S_DONE;
          g_d     = '0;
        end else begin
          g_d = g_q + G_STEP;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      g_q     <= '0;
      cap_q   <= '0;
      out_q   <= '0;
    end else begin
      state_q <= state_d;
      g_q     <= g_d;
      cap_q   <= cap_d;
      out_q   <= out_d;
    end
  end

  assign bus.busy     = (state_q == S_RUN);
  assign bus.done     = (state_q == S_DONE);
  assign bus.data_out = out_q;
endmodule

// File: tb/tb_inverse_revaluate.sv
// Directed and random checks for inverse_revaluate; honours INV_REVALUATE_DUAL_EN for latency.
module tb_inverse_revaluate;
  localparam int NC = 1600;
`ifdef INV_REVALUATE_DUAL_EN
  localparam int LAT  = 161;
  localparam int BUSY = 160;
`else
  localparam int LAT  = 321;
  localparam int BUSY = 320;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  inverse_revaluate_if #(.NUM_CELLS(NC)) bus ();

  inverse_revaluate dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  function automatic logic [4:0] chi_ref(input logic [4:0] a);
    logic [4:0] r;
    for (int i = 0; i < 5; i++)
      r[i] = a[i] ^ (~a[(i + 1) % 5] & a[(i + 2) % 5]);
    return r;
  endfunction

  function automatic logic [NC-1:0] chi_state(input logic [NC-1:0] s);
    logic [NC-1:0] r;
    r = '0;
    for (int g = 0; g < 320; g++)
      r[g*5 +: 5] = chi_ref(s[g*5 +: 5]);
    return r;
  endfunction

  task automatic check_int(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_vec(input string tag, input logic [NC-1:0] obs, input logic [NC-1:0] exp);
    int first;
    first = -1;
    for (int i = NC - 1; i >= 0; i--)
      if (obs[i] !== exp[i]) first = i;
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s differing_bits=%0d first_bad_bit=%0d observed_bit=%b expected_bit=%b",
             tag, $countones(obs ^ exp), first, obs[first], exp[first]);
    end
  endtask

  // Launch a run with data d; optionally pulse start (with ~d) at cycle poke.
  task automatic run(input logic [NC-1:0] d, input int poke, output int lat, output int bcnt,
                     output logic busy_at_done);
    int cyc;
    @(negedge clk);
    bus.start   = 1'b1;
    bus.data_in = d;
    @(negedge clk);
    bus.start   = 1'b0;
    bus.data_in = '0;
    cyc  = 1;
    lat  = -1;
    bcnt = 0;
    busy_at_done = 1'bx;
    while (cyc <= LAT + 20) begin
      if (cyc == poke) begin
        bus.start   = 1'b1;
        bus.data_in = ~d;
      end else begin
        bus.start = 1'b0;
      end
      if (bus.busy) bcnt++;
      if (bus.done) begin
        lat = cyc;
        busy_at_done = bus.busy;
        break;
      end
      @(negedge clk);
      cyc++;
    end
    bus.start = 1'b0;
  endtask

  logic [NC-1:0] s, exp_v, held;
  int            lat, bcnt, done_cnt;
  logic          bad;

  initial begin
    bus.start   = 1'b0;
    bus.data_in = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    check_int("reset_busy", int'(bus.busy), 0);
    check_int("reset_done", int'(bus.done), 0);
    check_vec("reset_data_out", bus.data_out, '0);

    // zeros: latency and busy length
    run('0, -1, lat, bcnt, bad);
    check_int("zero_latency", lat, LAT);
    check_int("zero_busy_cycles", bcnt, BUSY);
    check_int("zero_busy_at_done", int'(bad), 0);
    check_vec("zero_data_out", bus.data_out, '0);

    // all ones is a fixed point of chi
    run('1, -1, lat, bcnt, bad);
    check_int("ones_latency", lat, LAT);
    check_vec("ones_data_out", bus.data_out, '1);
    held = bus.data_out;
    @(negedge clk);
    check_int("done_one_cycle", int'(bus.done), 0);
    check_vec("data_out_held", bus.data_out, held);

    // group 0 = 0x09 -> inv = 0x01
    s = '0; s[0] = 1'b1; s[3] = 1'b1;
    exp_v = '0; exp_v[0] = 1'b1;
    run(s, -1, lat, bcnt, bad);
    check_vec("group0_09", bus.data_out, exp_v);

    // last group 319 = 0x09
    s = '0; s[1595] = 1'b1; s[1598] = 1'b1;
    exp_v = '0; exp_v[1595] = 1'b1;
    run(s, -1, lat, bcnt, bad);
    check_int("group319_latency", lat, LAT);
    check_vec("group319_09", bus.data_out, exp_v);

    // random round trips
    for (int t = 0; t < 100; t++) begin
      for (int w = 0; w < NC / 32; w++) s[w*32 +: 32] = $urandom;
      run(chi_state(s), -1, lat, bcnt, bad);
      check_int("random_latency", lat, LAT);
      check_vec("random_roundtrip", bus.data_out, s);
    end

    // start at cycle 50 is ignored (poke data would give all ones)
    run('0, 50, lat, bcnt, bad);
    check_int("poke_latency", lat, LAT);
    check_vec("poke_data_out", bus.data_out, '0);
    @(negedge clk);
    check_int("poke_not_restarted", int'(bus.busy), 0);

    // make data_out nonzero, then reset mid-run at cycle 100 with a coincident start
    run('1, -1, lat, bcnt, bad);
    @(negedge clk);
    bus.start   = 1'b1;
    bus.data_in = '1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (99) @(negedge clk);
    check_int("pre_reset_busy", int'(bus.busy), 1);
    rst = 1'b1;
    bus.start = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    bus.start = 1'b0;
    check_int("rst_busy", int'(bus.busy), 0);
    check_int("rst_done", int'(bus.done), 0);
    check_vec("rst_data_out", bus.data_out, '0);
    @(negedge clk);
    check_int("rst_start_dropped", int'(bus.busy), 0);
    done_cnt = 0;
    for (int c = 0; c < LAT + 50; c++) begin
      if (bus.done) done_cnt++;
      @(negedge clk);
    end
    check_int("rst_no_done", done_cnt, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
